// File: rtl/brpred_gshare_btb_if.sv
// Lookup/update/statistics bundle between the IF/EX pipeline (master) and
// the brpred_gshare_btb branch predictor (slave).
interface brpred_gshare_btb_if #(
   parameter int ADDR_W        = 32,
   parameter int NUM_INDEX_BIT = 6,
   parameter int GHR_BITS      = 6
);
   logic                     rd_valid_i;
   logic [ADDR_W-1:0]        rd_pc_i;
   logic                     pred_taken_o;
   logic [ADDR_W-1:0]        pred_target_o;
   logic                     btb_hit_o;
   logic [NUM_INDEX_BIT-1:0] pred_idx_o;
   logic [GHR_BITS-1:0]      pred_ghr_o;
   logic                     upd_valid_i;
   logic [ADDR_W-1:0]        upd_pc_i;
   logic [NUM_INDEX_BIT-1:0] upd_idx_i;
   logic [GHR_BITS-1:0]      upd_ghr_i;
   logic                     upd_taken_i;
   logic [ADDR_W-1:0]        upd_target_i;
   logic                     upd_miss_i;
   logic [31:0]              stat_lookups_o;
   logic [31:0]              stat_misses_o;

   modport master (
      output rd_valid_i, rd_pc_i,
      output upd_valid_i, upd_pc_i, upd_idx_i, upd_ghr_i, upd_taken_i, upd_target_i, upd_miss_i,
      input  pred_taken_o, pred_target_o, btb_hit_o, pred_idx_o, pred_ghr_o,
      input  stat_lookups_o, stat_misses_o
   );

   modport slave (
      input  rd_valid_i, rd_pc_i,
      input  upd_valid_i, upd_pc_i, upd_idx_i, upd_ghr_i, upd_taken_i, upd_target_i, upd_miss_i,
      output pred_taken_o, pred_target_o, btb_hit_o, pred_idx_o, pred_ghr_o,
      output stat_lookups_o, stat_misses_o
   );
endinterface

// File: rtl/brpred_gshare_btb.sv
// gshare direction predictor with a direct-mapped tagged BTB for the IF stage.
// Define BRPRED_STATS_EN to build the lookup/mispredict statistics counters.
module brpred_gshare_btb #(
   parameter int ADDR_W        = 32,
   parameter int NUM_INDEX_BIT = 6,
   parameter int GHR_BITS      = 6,
   parameter int CNT_BITS      = 2,
   parameter int BTB_INDEX_BIT = 4,
   parameter int TAG_BITS      = 8
) (
   input logic                clk,
   input logic                rst_n,
   input logic                stall_i,
   brpred_gshare_btb_if.slave bp
);
   localparam int PHT_N = 1 << NUM_INDEX_BIT;
   localparam int BTB_N = 1 << BTB_INDEX_BIT;
   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

   // Shift one outcome into the youngest history position.
   function automatic logic [GHR_BITS-1:0] hist_push(input logic [GHR_BITS-1:0] h, input logic b);
      return GHR_BITS'({h, b});
   endfunction

   logic [CNT_BITS-1:0]      pht_r [PHT_N];
   logic                     btb_valid_r [BTB_N];
   logic [TAG_BITS-1:0]      btb_tag_r [BTB_N];
   logic [ADDR_W-1:0]        btb_tgt_r [BTB_N];
   logic [GHR_BITS-1:0]      ghr_r;

   logic [NUM_INDEX_BIT-1:0] rd_idx_s;
   logic [BTB_INDEX_BIT-1:0] rd_set_s;
   logic [TAG_BITS-1:0]      rd_tag_s;
   logic                     hit_s;
   logic                     taken_s;
   logic [BTB_INDEX_BIT-1:0] upd_set_s;
   logic [TAG_BITS-1:0]      upd_tag_s;
   logic                     pht_we_s;
   logic                     btb_we_s;
   logic [CNT_BITS-1:0]      cnt_cur_s;
   logic [CNT_BITS-1:0]      cnt_nxt_s;
   logic [GHR_BITS-1:0]      ghr_nxt_s;
   logic                     unused_s;

   // Zero-latency lookup; reads see table contents before this cycle's update.
   assign rd_idx_s  = bp.rd_pc_i[NUM_INDEX_BIT+1:2] ^ NUM_INDEX_BIT'(ghr_r);
   assign rd_set_s  = bp.rd_pc_i[BTB_INDEX_BIT+1:2];
   assign rd_tag_s  = bp.rd_pc_i[BTB_INDEX_BIT+TAG_BITS+1:BTB_INDEX_BIT+2];
   assign hit_s     = btb_valid_r[rd_set_s] && (btb_tag_r[rd_set_s] == rd_tag_s);
   assign taken_s   = hit_s && pht_r[rd_idx_s][CNT_BITS-1];

   assign bp.btb_hit_o     = hit_s;
   assign bp.pred_taken_o  = taken_s;
   assign bp.pred_target_o = hit_s ? btb_tgt_r[rd_set_s] : {ADDR_W{1'b0}};
   assign bp.pred_idx_o    = rd_idx_s;
   assign bp.pred_ghr_o    = ghr_r;

   assign upd_set_s = bp.upd_pc_i[BTB_INDEX_BIT+1:2];
   assign upd_tag_s = bp.upd_pc_i[BTB_INDEX_BIT+TAG_BITS+1:BTB_INDEX_BIT+2];
   assign pht_we_s  = !stall_i && bp.upd_valid_i;
   assign btb_we_s  = pht_we_s && bp.upd_taken_i;
   assign unused_s  = ^{bp.rd_pc_i, bp.upd_pc_i};

   // Saturating counter step for the resolved branch.
   always_comb begin
      cnt_cur_s = pht_r[bp.upd_idx_i];
      cnt_nxt_s = cnt_cur_s;
      if (bp.upd_taken_i) begin
         if (cnt_cur_s != CNT_MAX) cnt_nxt_s = cnt_cur_s + CNT_ONE;
         else                      cnt_nxt_s = cnt_cur_s;
      end else begin
         if (cnt_cur_s != CNT_ZERO) cnt_nxt_s = cnt_cur_s - CNT_ONE;
         else                       cnt_nxt_s = cnt_cur_s;
      end
   end

   // History next state: a mispredict repair overrides the speculative shift.
   always_comb begin
      ghr_nxt_s = ghr_r;
      if (stall_i) begin
         ghr_nxt_s = ghr_r;
      end else if (bp.upd_valid_i && bp.upd_miss_i) begin
         ghr_nxt_s = hist_push(bp.upd_ghr_i, bp.upd_taken_i);
      end else if (bp.rd_valid_i && hit_s) begin
         ghr_nxt_s = hist_push(ghr_r, taken_s);
      end else begin
         ghr_nxt_s = ghr_r;
      end
   end

   // Global history register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ghr_r <= {GHR_BITS{1'b0}};
      else        ghr_r <= ghr_nxt_s;
   end

   // Pattern history table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PHT_N; i++) pht_r[i] <= CNT_INIT;
      end else if (pht_we_s) begin
         pht_r[bp.upd_idx_i] <= cnt_nxt_s;
      end
   end

   // BTB valid bits; only these need reset since tag/target are qualified by them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_N; i++) btb_valid_r[i] <= 1'b0;
      end else if (btb_we_s) begin
         btb_valid_r[upd_set_s] <= 1'b1;
      end
   end

   // BTB tag and target payload.
   always_ff @(posedge clk) begin
      if (btb_we_s) begin
         btb_tag_r[upd_set_s] <= upd_tag_s;
         btb_tgt_r[upd_set_s] <= bp.upd_target_i;
      end
   end

`ifdef BRPRED_STATS_EN
   logic [31:0] stat_lookups_r;
   logic [31:0] stat_misses_r;

   // Wrapping statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_lookups_r <= 32'd0;
         stat_misses_r  <= 32'd0;
      end else if (!stall_i) begin
         if (bp.rd_valid_i && hit_s) stat_lookups_r <= stat_lookups_r + 32'd1;
         if (bp.upd_valid_i && bp.upd_miss_i) stat_misses_r <= stat_misses_r + 32'd1;
      end
   end

   assign bp.stat_lookups_o = stat_lookups_r;
   assign bp.stat_misses_o  = stat_misses_r;
`else
   assign bp.stat_lookups_o = 32'd0;
   assign bp.stat_misses_o  = 32'd0;
`endif
endmodule

// File: tb/tb_brpred_gshare_btb.sv
// Bench for brpred_gshare_btb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a table-level model.
module tb_brpred_gshare_btb;
   logic clk;
   logic rst_n;
   logic stall_i;
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 0;

   brpred_gshare_btb_if bif ();

   brpred_gshare_btb dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .stall_i (stall_i),
      .bp      (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: plain integers per table entry.
   int          m_cnt [64];
   bit          m_v   [16];
   int          m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_ghr;
   logic [31:0] m_sl;
   logic [31:0] m_sm;

   function automatic int f_idx(logic [31:0] pc, int ghr);
      return ((int'(pc >> 2) % 64) ^ ghr) % 64;
   endfunction
   function automatic int f_set(logic [31:0] pc);
      return int'(pc >> 2) % 16;
   endfunction
   function automatic int f_tag(logic [31:0] pc);
      return int'(pc >> 6) % 256;
   endfunction

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model advance on each clock edge / async reset.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_cnt[i] = 1;
            for (int i = 0; i < 16; i++) m_v[i] = 0;
            m_ghr = 0;
            m_sl  = 0;
            m_sm  = 0;
         end else if (!stall_i) begin
            int  ri, rs, ui, us;
            bit  lh, lt;
            ri = f_idx(bif.rd_pc_i, m_ghr);
            rs = f_set(bif.rd_pc_i);
            lh = m_v[rs] && (m_tag[rs] == f_tag(bif.rd_pc_i));
            lt = lh && (m_cnt[ri] >= 2);
            if (bif.upd_valid_i) begin
               ui = int'(bif.upd_idx_i);
               if (bif.upd_taken_i) m_cnt[ui] = (m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1;
               else                 m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
               if (bif.upd_taken_i) begin
                  us = f_set(bif.upd_pc_i);
                  m_v[us]   = 1;
                  m_tag[us] = f_tag(bif.upd_pc_i);
                  m_tgt[us] = bif.upd_target_i;
               end
            end
            if (bif.upd_valid_i && bif.upd_miss_i)
               m_ghr = (int'(bif.upd_ghr_i) * 2 + int'(bif.upd_taken_i)) % 64;
            else if (bif.rd_valid_i && lh)
               m_ghr = (m_ghr * 2 + int'(lt)) % 64;
`ifdef BRPRED_STATS_EN
            if (bif.rd_valid_i && lh) m_sl = m_sl + 32'd1;
            if (bif.upd_valid_i && bif.upd_miss_i) m_sm = m_sm + 32'd1;
`endif
         end
      end
   end

   // Every-cycle comparison of lookup outputs against the model.
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         int ri, rs;
         bit eh, et;
         ri = f_idx(bif.rd_pc_i, m_ghr);
         rs = f_set(bif.rd_pc_i);
         eh = m_v[rs] && (m_tag[rs] == f_tag(bif.rd_pc_i));
         et = eh && (m_cnt[ri] >= 2);
         cmp("model_hit",    32'(bif.btb_hit_o),    32'(eh));
         cmp("model_taken",  32'(bif.pred_taken_o), 32'(et));
         cmp("model_target", bif.pred_target_o,     eh ? m_tgt[rs] : 32'd0);
         cmp("model_idx",    32'(bif.pred_idx_o),   32'(ri));
         cmp("model_ghr",    32'(bif.pred_ghr_o),   32'(m_ghr));
         cmp("model_stat_l", bif.stat_lookups_o,    m_sl);
         cmp("model_stat_m", bif.stat_misses_o,     m_sm);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look(logic [31:0] pc, logic v);
      bif.rd_pc_i    = pc;
      bif.rd_valid_i = v;
   endtask

   task automatic upd(logic v, logic [31:0] pc, logic [5:0] idx, logic [5:0] ghr,
                      logic tk, logic [31:0] tgt, logic miss);
      bif.upd_valid_i  = v;
      bif.upd_pc_i     = pc;
      bif.upd_idx_i    = idx;
      bif.upd_ghr_i    = ghr;
      bif.upd_taken_i  = tk;
      bif.upd_target_i = tgt;
      bif.upd_miss_i   = miss;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   logic [31:0] pool [8] = '{32'h100, 32'h210, 32'h300, 32'h1100,
                             32'h2c, 32'h44, 32'h3f8, 32'h5a4};

   initial begin
      rst_n   = 1'b0;
      stall_i = 1'b0;
      look(32'h0, 1'b0);
      upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Reset state seen through a lookup of 0x100.
      step(); look(32'h100, 1'b1);
      settle();
      cmp("rst_hit",    32'(bif.btb_hit_o),    32'd0);
      cmp("rst_taken",  32'(bif.pred_taken_o), 32'd0);
      cmp("rst_target", bif.pred_target_o,     32'd0);
      cmp("rst_ghr",    32'(bif.pred_ghr_o),   32'd0);

      // Mispredicted taken branch installs BTB entry and repairs history to 1;
      // the next lookup then indexes PHT entry 1 (still weakly not-taken).
      step(); look(32'h100, 1'b0); upd(1'b1, 32'h100, 6'd0, 6'd0, 1'b1, 32'h80, 1'b1);
      step(); upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0);
      settle();
      cmp("first_hit",    32'(bif.btb_hit_o),    32'd1);
      cmp("first_target", bif.pred_target_o,     32'h80);
      cmp("first_ghr",    32'(bif.pred_ghr_o),   32'd1);
      cmp("first_idx",    32'(bif.pred_idx_o),   32'd1);
      cmp("first_taken",  32'(bif.pred_taken_o), 32'd0);

      // Counter at index 5 saturates at 3; lookup 0x210 with GHR=1 maps to index 5.
      step(); upd(1'b1, 32'h210, 6'd5, 6'd0, 1'b1, 32'h300, 1'b0);
      repeat (3) step();
      step(); upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0); look(32'h210, 1'b0);
      settle();
      cmp("sat_idx",   32'(bif.pred_idx_o),   32'd5);
      cmp("sat_taken", 32'(bif.pred_taken_o), 32'd1);
      step(); upd(1'b1, 32'h210, 6'd5, 6'd0, 1'b0, 32'h0, 1'b0);
      step(); upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0);
      settle();
      cmp("dec1_taken",  32'(bif.pred_taken_o), 32'd1);
      cmp("dec1_target", bif.pred_target_o,     32'h300);
      step(); upd(1'b1, 32'h210, 6'd5, 6'd0, 1'b0, 32'h0, 1'b0);
      step(); upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0);
      settle();
      cmp("dec2_taken", 32'(bif.pred_taken_o), 32'd0);

      // Repair beats the speculative shift in the same cycle.
      step(); look(32'h210, 1'b1); upd(1'b1, 32'h400, 6'd7, 6'b101010, 1'b0, 32'h0, 1'b1);
      step(); look(32'h210, 1'b0); upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0);
      settle();
      cmp("repair_ghr", 32'(bif.pred_ghr_o), 32'b010100);

      // Stall freezes everything; the held update lands once afterwards.
      step(); stall_i = 1'b1; look(32'h210, 1'b1);
      upd(1'b1, 32'h300, 6'd9, 6'b000011, 1'b1, 32'h444, 1'b1);
      repeat (3) step();
      settle();
      cmp("stall_ghr", 32'(bif.pred_ghr_o), 32'b010100);
      look(32'h300, 1'b1);
      #1;
      cmp("stall_btb", 32'(bif.btb_hit_o), 32'd0);
      step(); stall_i = 1'b0;
      step(); look(32'h300, 1'b0); upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0);
      settle();
      cmp("unstall_ghr",    32'(bif.pred_ghr_o), 32'b000111);
      cmp("unstall_target", bif.pred_target_o,   32'h444);

      // Asynchronous reset mid-operation.
      step(); rst_n = 1'b0;
      #1;
      cmp("arst_hit",    32'(bif.btb_hit_o),    32'd0);
      cmp("arst_taken",  32'(bif.pred_taken_o), 32'd0);
      cmp("arst_target", bif.pred_target_o,     32'd0);
      cmp("arst_ghr",    32'(bif.pred_ghr_o),   32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Statistics: three hit lookups plus one mispredict.
      step(); upd(1'b1, 32'h100, 6'd0, 6'd0, 1'b1, 32'h80, 1'b0);
      step(); upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0); look(32'h100, 1'b1);
      repeat (2) step();
      step(); look(32'h100, 1'b0); upd(1'b1, 32'h500, 6'd3, 6'd0, 1'b0, 32'h0, 1'b1);
      step(); upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0);
      settle();
`ifdef BRPRED_STATS_EN
      cmp("stat_lookups", bif.stat_lookups_o, 32'd3);
      cmp("stat_misses",  bif.stat_misses_o,  32'd1);
`else
      cmp("stat_lookups", bif.stat_lookups_o, 32'd0);
      cmp("stat_misses",  bif.stat_misses_o,  32'd0);
`endif

      // Randomized traffic; pc[1:0] randomised to exercise its irrelevance.
      for (int n = 0; n < 3000; n++) begin
         step();
         stall_i = ($urandom_range(0, 7) == 0);
         look(pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         upd(($urandom_range(0, 2) == 0), pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
             6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)), $urandom,
             ($urandom_range(0, 3) == 0));
      end
      step();
      stall_i = 1'b0;
      upd(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0);
      settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
